// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (HS/VS/BLANK_N, active X/Y, vblank lock, frame pulse and counter), all outputs registered one clock behind the counters
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  output logic        o_VGA_lock,
  output logic        o_frame_start,
  output logic [7:0]  o_frame_cnt
);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [10:0] h_cnt, v_cnt;
  logic h_act, v_act, fs;
  always_comb begin
    h_act = h_cnt < HA;
    v_act = v_cnt < VA;
    fs    = h_cnt == '0 && v_cnt == '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_VGA_HS      <= ~HS_POL;
      o_VGA_VS      <= ~VS_POL;
      o_VGA_BLANK_N <= 1'b0;
      o_VGA_X       <= '0;
      o_VGA_Y       <= '0;
      o_VGA_lock    <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      h_cnt         <= h_cnt == HL ? '0 : h_cnt + 11'd1;
      v_cnt         <= h_cnt != HL ? v_cnt : v_cnt == VL ? '0 : v_cnt + 11'd1;
      o_VGA_HS      <= (h_cnt >= HS0 && h_cnt < HS1) ? HS_POL : ~HS_POL;
      o_VGA_VS      <= (v_cnt >= VS0 && v_cnt < VS1) ? VS_POL : ~VS_POL;
      o_VGA_BLANK_N <= h_act && v_act;
      o_VGA_X       <= h_act ? h_cnt : '0;
      o_VGA_Y       <= v_act ? v_cnt : '0;
      o_VGA_lock    <= v_act;
      o_frame_start <= fs;
      o_frame_cnt   <= o_frame_cnt + {7'd0, fs};
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized check of vga_timing_gen against a position-from-time raster model
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_lock, o_frame_start;
  logic [10:0] o_VGA_X, o_VGA_Y;
  logic [7:0] o_frame_cnt;
  int tests = 0;
  int fails = 0;
  int t = 0;
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .o_VGA_HS(o_VGA_HS),
    .o_VGA_VS(o_VGA_VS),
    .o_VGA_BLANK_N(o_VGA_BLANK_N),
    .o_VGA_X(o_VGA_X),
    .o_VGA_Y(o_VGA_Y),
    .o_VGA_lock(o_VGA_lock),
    .o_frame_start(o_frame_start),
    .o_frame_cnt(o_frame_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_hs"}, 32'(o_VGA_HS), 0);
    check({tag, "_vs"}, 32'(o_VGA_VS), 0);
    check({tag, "_blank_n"}, 32'(o_VGA_BLANK_N), 0);
    check({tag, "_x"}, 32'(o_VGA_X), 0);
    check({tag, "_y"}, 32'(o_VGA_Y), 0);
    check({tag, "_lock"}, 32'(o_VGA_lock), 0);
    check({tag, "_fs"}, 32'(o_frame_start), 0);
    check({tag, "_fcnt"}, 32'(o_frame_cnt), 0);
  endtask
  // Edge t after release shows the raster position reached t-1 clocks after (0,0).
  task automatic step();
    int p, x, y, act;
    @(posedge i_clk);
    #1;
    t++;
    p = (t - 1) % TOT;
    x = p % HT;
    y = p / HT;
    act = (x < HA && y < VA) ? 1 : 0;
    check("hs", 32'(o_VGA_HS), (x >= HA + HF && x < HA + HF + HS) ? 1 : 0);
    check("vs", 32'(o_VGA_VS), (y >= VA + VF && y < VA + VF + VS) ? 1 : 0);
    check("blank_n", 32'(o_VGA_BLANK_N), act);
    check("x", 32'(o_VGA_X), x < HA ? x : 0);
    check("y", 32'(o_VGA_Y), y < VA ? y : 0);
    check("lock", 32'(o_VGA_lock), y < VA ? 1 : 0);
    check("fs", 32'(o_frame_start), p == 0 ? 1 : 0);
    check("fcnt", 32'(o_frame_cnt), ((t - 1) / TOT + 1) % 256);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic release_rst();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    t = 0;
  endtask
  task automatic async_reset(input string tag);
    #($urandom_range(1, 2));
    i_rst_n = 1'b0;
    #1;
    check_reset({tag, "_async"});
    repeat (2) @(posedge i_clk);
    #1;
    check_reset({tag, "_hold"});
    release_rst();
  endtask
  initial begin
    #2;
    check_reset("por");
    @(posedge i_clk);
    #1;
    check_reset("por_hold");
    release_rst();
    run(257 * TOT + int'($urandom_range(0, TOT - 1)));
    run((33 - (t % TOT) + TOT) % TOT);
    async_reset("mid_2_5");
    run(TOT + 20);
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(1, 3 * TOT)));
      async_reset("rand");
    end
    run(2 * TOT);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
